simple_cpu: RTL and testbench

SIMPLE_CPU -- requirements
Module: simple_cpu

---
 rtl/simple_cpu_pkg.sv | 41 ++++
 rtl/reg_mem.sv | 25 ++
 rtl/simple_cpu.sv | 109 ++++++++++
 tb/tb_simple_cpu.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/simple_cpu_pkg.sv
// Shared encodings for simple_cpu: instruction classes, ALU functions,
// FSM states, instruction field positions and default widths.
package simple_cpu_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ADDR_BITS   = 5;
  localparam int DEF_INSTR_WIDTH = 20;

  localparam int CLS_MSB = 19;
  localparam int CLS_LSB = 18;
  localparam int X1_MSB  = 17;
  localparam int X1_LSB  = 16;
  localparam int X2_MSB  = 15;
  localparam int X2_LSB  = 14;
  localparam int X3_MSB  = 13;
  localparam int X3_LSB  = 12;
  localparam int OFF_MSB = 11;
  localparam int OFF_LSB = 4;
  localparam int FN_MSB  = 3;
  localparam int FN_LSB  = 0;
  localparam int OFF_W   = OFF_MSB - OFF_LSB + 1;

  typedef enum logic [1:0] {
    CLS_NOP   = 2'b00,
    CLS_ALU   = 2'b01,
    CLS_LOAD  = 2'b10,
    CLS_STORE = 2'b11
  } instr_class_e;

  typedef enum logic [3:0] {
    FN_ADD = 4'd0,
    FN_SUB = 4'd1
  } alu_func_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2
  } state_e;

endpackage

// File: rtl/reg_mem.sv
// Data memory for simple_cpu: synchronous write, combinational read, no reset.
module reg_mem
  import simple_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  input  logic                  clk,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[addr] <= data_in;
    end
  end

  assign data_out = mem[addr];

endmodule

// File: rtl/simple_cpu.sv
// Three-state (FETCH/EXEC/WB) CPU with a 4-entry register file, wrapping
// ADD/SUB ALU and register+offset loads/stores into a reg_mem data memory.
module simple_cpu
  import simple_cpu_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
) (
  input logic                   clk,
  input logic                   rst,
  input logic [INSTR_WIDTH-1:0] instruction
);

  localparam int SUM_W = (DATA_WIDTH > OFF_W) ? DATA_WIDTH : OFF_W;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] ir_q;
  logic [DATA_WIDTH-1:0]  alu_q, alu_d;
  logic [ADDR_BITS-1:0]   ea_q, ea_d;
  logic [DATA_WIDTH-1:0]  regfile [0:3];

  instr_class_e           cls;
  logic [1:0]             x1, x2, x3;
  logic [OFF_W-1:0]       off;
  logic [3:0]             fn;
  logic                   rf_we;
  logic [DATA_WIDTH-1:0]  rf_wdata;
  logic                   mem_wen;
  logic [DATA_WIDTH-1:0]  mem_rdata;

  assign cls = instr_class_e'(ir_q[CLS_MSB:CLS_LSB]);
  assign x1  = ir_q[X1_MSB:X1_LSB];
  assign x2  = ir_q[X2_MSB:X2_LSB];
  assign x3  = ir_q[X3_MSB:X3_LSB];
  assign off = ir_q[OFF_MSB:OFF_LSB];
  assign fn  = ir_q[FN_MSB:FN_LSB];

  always_comb begin
    state_d  = state_q;
    alu_d    = alu_q;
    ea_d     = ea_q;
    rf_we    = 1'b0;
    rf_wdata = alu_q;
    mem_wen  = 1'b0;
    case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_WB;
        alu_d   = (fn == FN_SUB) ? regfile[x2] - regfile[x3]
                                 : regfile[x2] + regfile[x3];
        ea_d    = ADDR_BITS'(SUM_W'(regfile[x2]) + SUM_W'(off));
      end
      ST_WB: begin
        state_d = ST_FETCH;
        case (cls)
          CLS_ALU:   rf_we = (fn == FN_ADD) || (fn == FN_SUB);
          CLS_LOAD: begin
            rf_we    = 1'b1;
            rf_wdata = mem_rdata;
          end
          CLS_STORE: mem_wen = 1'b1;
          default:   ;
        endcase
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      alu_q   <= '0;
      ea_q    <= '0;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
      ea_q    <= ea_d;
      if (state_q == ST_FETCH) begin
        ir_q <= instruction;
      end
    end
  end

  // Operands are read in EXEC and the write lands in WB, so X1 aliasing
  // with X2/X3 naturally sees the pre-write value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        regfile[i] <= DATA_WIDTH'(i);
      end
    end else if (rf_we) begin
      regfile[x1] <= rf_wdata;
    end
  end

  reg_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) dmem (
    .addr    (ea_q),
    .data_in (regfile[x1]),
    .wen     (mem_wen),
    .clk     (clk),
    .data_out(mem_rdata)
  );

endmodule

// File: tb/tb_simple_cpu.sv
// Self-checking bench for simple_cpu and reg_mem against a behavioural model.
module tb_simple_cpu;
  import simple_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] instruction = '0;

  logic [4:0]  u_addr = '0;
  logic [7:0]  u_din  = '0;
  logic        u_wen  = 1'b0;
  logic [7:0]  u_dout;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_rf  [4];
  logic [7:0] m_mem [32];
  logic [7:0] u_exp [32];

  always #5 clk = ~clk;

  simple_cpu dut (
    .clk        (clk),
    .rst        (rst),
    .instruction(instruction)
  );

  reg_mem u_mem (
    .addr    (u_addr),
    .data_in (u_din),
    .wen     (u_wen),
    .clk     (clk),
    .data_out(u_dout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'(i);
  endtask

  task automatic model(input logic [19:0] ins, output int ea);
    logic [1:0] x1, x2, x3;
    x1 = ins[17:16];
    x2 = ins[15:14];
    x3 = ins[13:12];
    ea = (int'(m_rf[x2]) + int'(ins[11:4])) % 32;
    case (ins[19:18])
      2'b01: begin
        if (ins[3:0] == 4'd0) m_rf[x1] = m_rf[x2] + m_rf[x3];
        else if (ins[3:0] == 4'd1) m_rf[x1] = m_rf[x2] - m_rf[x3];
      end
      2'b10: m_rf[x1] = m_mem[ea];
      2'b11: m_mem[ea] = m_rf[x1];
      default: ;
    endcase
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_r%0d", tag, i), 32'(dut.regfile[i]), 32'(m_rf[i]));
    end
  endtask

  task automatic run(input logic [19:0] ins, input string tag);
    int ea;
    instruction = ins;
    @(posedge clk); #1;
    instruction = 20'($urandom);
    check({tag, "_wen_exec"}, 32'(dut.dmem.wen), 32'd0);
    @(posedge clk); #1;
    check({tag, "_wen_wb"}, 32'(dut.dmem.wen), 32'(ins[19:18] == 2'b11));
    @(posedge clk); #1;
    model(ins, ea);
    check_regs(tag);
    if (ins[19:18] == 2'b11) begin
      check({tag, "_mem"}, 32'(dut.dmem.mem[ea]), 32'(m_mem[ea]));
    end
    $display("instr %05h (%s) done", ins, tag);
  endtask

  initial begin
    logic [19:0] ins;
    logic [7:0]  off;

    // Standalone memory: wrapping writes, then combinational reads.
    for (int i = 10; i <= 42; i++) begin
      u_addr = 5'((i + 2) % 32);
      u_din  = 8'(i);
      u_wen  = 1'b1;
      u_exp[(i + 2) % 32] = 8'(i);
      @(posedge clk); #1;
    end
    u_wen = 1'b0;
    for (int a = 0; a < 32; a++) begin
      u_addr = 5'(a);
      #1;
      check($sformatf("regmem_a%0d", a), 32'(u_dout), 32'(u_exp[a]));
    end
    u_addr = 5'd12; #1; check("regmem_wrap12", 32'(u_dout), 32'd42);
    u_addr = 5'd13; #1; check("regmem_13",     32'(u_dout), 32'd11);
    u_addr = 5'd0;  #1; check("regmem_0",      32'(u_dout), 32'd30);
    $display("reg_mem sweep done");

    // Reset state.
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check_regs("reset");
    check("reset_ir", 32'(dut.ir_q), 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(ST_FETCH));
    check("reset_wen", 32'(dut.dmem.wen), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed sequence.
    run(20'b01_00_01_11_00000000_0000, "add_r0");
    check("add_r0_const", 32'(dut.regfile[0]), 32'd4);
    run(20'b01_01_00_11_00000000_0000, "add_r1");
    check("add_r1_const", 32'(dut.regfile[1]), 32'd7);
    run(20'b01_11_00_10_00000000_0001, "sub_r3");
    check("sub_r3_const", 32'(dut.regfile[3]), 32'd2);
    run(20'b11_01_10_00_00001111_0000, "st17");
    check("st17_const", 32'(dut.dmem.mem[17]), 32'd7);
    run(20'b11_00_11_00_00010110_0000, "st24");
    check("st24_const", 32'(dut.dmem.mem[24]), 32'd4);
    run(20'b10_11_10_00_00001111_0000, "ld17");
    check("ld17_const", 32'(dut.regfile[3]), 32'd7);

    // Reset during EXEC of a store of 2 to address 17 must abort it.
    instruction = 20'b11_10_10_00_00001111_0000;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    model_reset();
    check_regs("abort");
    check("abort_wen", 32'(dut.dmem.wen), 32'd0);
    @(posedge clk); #1;
    check("abort_mem17", 32'(dut.dmem.mem[17]), 32'd7);
    rst = 1'b0;

    run(20'b01_00_00_11_00000000_0001, "sub_wrap");
    check("sub_wrap_const", 32'(dut.regfile[0]), 32'hFD);
    run(20'b01_10_00_10_00000000_0000, "alias_r2");
    check("alias_r2_const", 32'(dut.regfile[2]), 32'hFF);
    run(20'b01_00_10_01_00000000_0000, "add_wrap");
    check("add_wrap_const", 32'(dut.regfile[0]), 32'd0);
    run(20'b01_11_11_11_00000000_0000, "r3x2");
    run(20'b01_00_11_11_00000000_0000, "r0_12");
    run(20'b01_00_00_00_00000000_0000, "r0_24");
    run(20'b01_00_00_11_00000000_0000, "r0_30");
    check("r0_30_const", 32'(dut.regfile[0]), 32'd30);
    run(20'b11_00_00_00_00000101_0000, "st_wrap");
    check("st_wrap_const", 32'(dut.dmem.mem[3]), 32'd30);
    run(20'b10_11_00_00_00000101_0000, "ld_wrap");
    check("ld_wrap_const", 32'(dut.regfile[3]), 32'd30);

    // Fill every memory word with a known value before random traffic.
    for (int a = 0; a < 32; a++) begin
      off = 8'(a) - m_rf[0];
      ins = {2'b11, 2'($urandom_range(0, 3)), 2'b00, 2'b00, off, 4'd0};
      run(ins, $sformatf("fill%0d", a));
    end

    for (int n = 0; n < 150; n++) begin
      ins = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             8'($urandom), 4'($urandom_range(0, 3))};
      run(ins, $sformatf("rand%0d", n));
    end

    for (int a = 0; a < 32; a++) begin
      check($sformatf("final_mem%0d", a), 32'(dut.dmem.mem[a]), 32'(m_mem[a]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
